// File: rtl/vector_resampler_pkg.sv
// Shared definitions for the vector resampler.
// Contents: index-mode encodings, FSM state encoding and a constant-evaluable
// clog2 used to size index and beat counters (never returns less than 1).
package vector_resampler_pkg;

  typedef enum logic [1:0] {
    MODE_NEAREST = 2'd0,
    MODE_TILE    = 2'd1,
    MODE_PAD     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ceiling log2 with a floor of one bit so single-entry ranges still get a port.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/vector_resampler_index_rom.sv
// resample_index_rom: maps an output element index to its source element.
// Ports:
//   idx_i  - output element index j (only values < OUTPUT_COUNT are meaningful)
//   mode_i - NEAREST / TILE / PAD selection
//   src_o  - source element index into the input vector
//   pad_o  - high when the element is to be filled with the pad value
// All tables are elaboration-time constants, so no divider is built.
module resample_index_rom
  import vector_resampler_pkg::*;
#(
  parameter int INPUT_COUNT  = 128,
  parameter int OUTPUT_COUNT = 256,
  parameter int IW           = clog2(INPUT_COUNT),
  parameter int OW           = clog2(OUTPUT_COUNT)
) (
  input  logic [OW-1:0] idx_i,
  input  mode_e         mode_i,
  output logic [IW-1:0] src_o,
  output logic          pad_o
);

  // Tables span the full index range; entries past OUTPUT_COUNT are zero.
  localparam int TAB = 1 << OW;

  logic [IW-1:0] near_tab [TAB];
  logic [IW-1:0] tile_tab [TAB];
  logic [IW-1:0] pads_tab [TAB];
  logic          flag_tab [TAB];

  for (genvar j = 0; j < TAB; j++) begin : g_tab
    if (j < OUTPUT_COUNT) begin : g_live
      assign near_tab[j] = IW'((j * INPUT_COUNT) / OUTPUT_COUNT);
      assign tile_tab[j] = IW'(j % INPUT_COUNT);
      if (j < INPUT_COUNT) begin : g_copy
        assign pads_tab[j] = IW'(j);
        assign flag_tab[j] = 1'b0;
      end else begin : g_fill
        assign pads_tab[j] = '0;
        assign flag_tab[j] = 1'b1;
      end
    end else begin : g_dead
      assign near_tab[j] = '0;
      assign tile_tab[j] = '0;
      assign pads_tab[j] = '0;
      assign flag_tab[j] = 1'b0;
    end
  end

  // Select the table for the active mode.
  always_comb begin
    src_o = '0;
    pad_o = 1'b0;
    case (mode_i)
      MODE_NEAREST: src_o = near_tab[idx_i];
      MODE_TILE:    src_o = tile_tab[idx_i];
      MODE_PAD: begin
        src_o = pads_tab[idx_i];
        pad_o = flag_tab[idx_i];
      end
      default: begin
        src_o = '0;
        pad_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vector_resampler.sv
// vector_resampler: retargets an INPUT_COUNT-element vector to OUTPUT_COUNT
// elements, writing LANES output elements per beat.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   start, mode      - request and index mode (sampled together in IDLE)
//   abort            - cancels an in-flight transfer
//   vector_in        - source vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   vector_out       - result vector, same packing, held between transfers
//   busy, done, err  - transfer in progress / completion pulse / rejected start
module vector_resampler
  import vector_resampler_pkg::*;
#(
  parameter int                    INPUT_COUNT  = 128,
  parameter int                    OUTPUT_COUNT = 256,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    LANES        = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [1:0]                         mode,
  input  logic [DATA_WIDTH*INPUT_COUNT-1:0]  vector_in,
  output logic [DATA_WIDTH*OUTPUT_COUNT-1:0] vector_out,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int           BEATS     = (OUTPUT_COUNT + LANES - 1) / LANES;
  localparam int           BW        = clog2(BEATS);
  localparam int           IW        = clog2(INPUT_COUNT);
  localparam int           OW        = clog2(OUTPUT_COUNT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (INPUT_COUNT <= 0 || OUTPUT_COUNT <= 0) begin : g_bad_count
    $error("vector_resampler: INPUT_COUNT and OUTPUT_COUNT must be positive");
  end
  if (LANES < 1 || LANES > OUTPUT_COUNT) begin : g_bad_lanes
    $error("vector_resampler: LANES must be in 1..OUTPUT_COUNT");
  end

  state_e                            state_q;
  mode_e                             mode_q;
  logic [BW-1:0]                     beat_q;
  logic [DATA_WIDTH*INPUT_COUNT-1:0] buf_q;
  logic [DATA_WIDTH*OUTPUT_COUNT-1:0] vector_out_q;
  logic                              busy_q;
  logic                              done_q;
  logic                              err_q;

  logic [LANES-1:0]      lane_ok_s;
  logic [OW-1:0]         lane_idx_s  [LANES];
  logic [DATA_WIDTH-1:0] lane_data_s [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [31:0]   lane_j_s;
    logic [IW-1:0] src_s;
    logic          pad_s;

    assign lane_j_s      = 32'(beat_q) * 32'(LANES) + 32'(k);
    // Lanes past the end of the output vector on the final beat stay idle.
    assign lane_ok_s[k]  = lane_j_s < 32'(OUTPUT_COUNT);
    assign lane_idx_s[k] = lane_ok_s[k] ? lane_j_s[OW-1:0] : '0;

    resample_index_rom #(
      .INPUT_COUNT  (INPUT_COUNT),
      .OUTPUT_COUNT (OUTPUT_COUNT)
    ) u_rom (
      .idx_i  (lane_idx_s[k]),
      .mode_i (mode_q),
      .src_o  (src_s),
      .pad_o  (pad_s)
    );

    assign lane_data_s[k] = pad_s ? PAD_VALUE : buf_q[src_s*DATA_WIDTH +: DATA_WIDTH];
  end

  // Control FSM, beat counter, input capture and per-lane output writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_NEAREST;
      beat_q       <= '0;
      buf_q        <= '0;
      vector_out_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // abort takes priority over a simultaneous start.
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (start) begin
            if (mode_e'(mode) == MODE_RSVD) begin
              err_q <= 1'b1;
            end else begin
              buf_q   <= vector_in;
              mode_q  <= mode_e'(mode);
              beat_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // The beat at the current edge is always written, even when aborting.
          for (int k = 0; k < LANES; k++) begin
            if (lane_ok_s[k]) begin
              vector_out_q[32'(lane_idx_s[k])*DATA_WIDTH +: DATA_WIDTH] <= lane_data_s[k];
            end
          end
          if (abort || beat_q == LAST_BEAT) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= !abort;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vector_out = vector_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
